toggle_cover_collector: RTL and testbench
=========================================

// Module: toggle_cover_collector
// PURPOSE
//  Upstream feeder for the per-group toggle-cover reporters. Samples a WIDTH-bit watched signal
//  group and detects rising and falling edges per bit. Drives the reporter's `valid` vector with
//  per-bit toggle pulses. Also serialises each first-ever hit of a cover point (bit, direction)
//  to the fuzzing/BMC harness over a valid/ready stream, and keeps a running count of covered points.
// PARAMETERS
//  WIDTH        120  number of watched bits; cover points = 2*WIDTH
//  PT_W         $clog2(2*WIDTH)  width of point id (localparam-derived; do not override)
// PORTS
//  clock        in   1        single clock, all state on posedge
//  reset        in   1        synchronous, active-high
//  sig          in   WIDTH    watched signal group
//  clear_cov    in   1        one-cycle pulse: forget coverage (covered/pending/count)
//  toggle_vld   out  WIDTH    per-bit toggle pulse -> reporter `valid`
//  hit_valid    out  1        new-hit stream valid
//  hit_ready    in   1        new-hit stream ready
//  hit_point    out  PT_W     point id = 2*bit + dir (dir 0 = rise, 1 = fall)
//  hit_count    out  PT_W+1   number of distinct points covered since reset/clear
// BEHAVIOUR
//  - Reset: prev, armed, covered[2W], pending[2W], toggle_vld, hit_valid, hit_point, hit_count all 0.
//  - armed goes 1 on the first cycle after reset. While armed = 0, only prev is loaded; no edges.
//  - rise = sig & ~prev; fall = ~sig & prev; prev <= sig every cycle.
//  - toggle_vld <= rise | fall (registered). It appears 1 cycle after the edge is sampled and
//    lasts 1 cycle per edge. Every toggle pulses it, including ones already covered.
//  - new = {rise,fall interleaved to point ids} & ~covered. covered |= new and pending |= new in the same cycle.
//  - hit_count += popcount(new) (saturation not needed: max 2*WIDTH).
//  - Pick: when hit_valid = 0, or when hit_valid & hit_ready, load the lowest-id set bit of pending
//    (after this cycle's clear of the emitted bit) into hit_point, set hit_valid, and clear that
//    pending bit. If pending is empty, hit_valid <= 0.
//    Throughput: 1 point/cycle. Pick-to-valid latency: 1 cycle.
//  - Stream rules: hit_point is stable while hit_valid & ~hit_ready. hit_valid is never withdrawn
//    without a handshake. No event is ever dropped: the pending bitmap is the buffer.
//  - Simultaneous events: pending_next = (pending & ~picked) | new. A point cannot be both new and
//    picked in the same cycle.
//  - clear_cov: covered, pending, hit_count <= 0; prev and armed are untouched. An in-flight hit
//    (hit_valid = 1) is held until accepted. Edges sampled in the clear cycle are discarded for
//    coverage but still pulse toggle_vld.
//  - reset wins over clear_cov. Reset mid-stream drops hit_valid immediately; the harness must
//    discard.
// CONFIGURATION
//  TOGGLE_COVER_GATE_EN defined: adds input `cover_en` (1 bit, after clear_cov).
//    - cover_en = 0: rise/fall are forced to 0 (no toggle_vld, no new hits); prev still tracks sig.
//    - Hits already pending still drain.
//  Undefined: no port; detection is always enabled.
// STRUCTURE
//  Package toggle_cover_pkg:
//    - typedef enum logic {DIR_RISE = 0, DIR_FALL = 1} tc_dir_e
//    - function point id = {bit, dir}
//    - function popcount
//  Sub-module toggle_cover_pick: parameter N; input req[N];
//    outputs gnt_valid and gnt_idx ($clog2(N)), giving the lowest set bit (purely combinational).
//  Top holds prev/armed/covered/pending/count and the output register.
// TESTING
//  1 Reset, then sig toggles in cycle 0 after reset -> no toggle_vld, no hit (arm cycle).
//  2 sig[5] 0->1, later 1->0, hit_ready = 1 -> toggle_vld[5] pulses twice; hits 10 then 11 (one
//    cycle after each edge); hit_count = 2. Repeating the toggles gives pulses but no new hits.
//  3 sig[3:0] 0->F in one cycle, hit_ready = 0 for 5 cycles, then 1 -> hit_point 0 held stable;
//    then 2, 4, 6 on consecutive cycles; hit_count = 4 immediately.
//  4 Back-pressure plus new hits: with point 6 stalled, sig[0] falls -> point 1 is emitted right
//    after 6 is accepted, before any higher id.
//  5 clear_cov while hit_valid = 1, pending nonempty -> current hit is still delivered; pending is
//    flushed; hit_count = 0. Retoggling sig[5] re-reports 10.
//  6 TOGGLE_COVER_GATE_EN with cover_en = 0 during a sig[7] rise -> no toggle_vld, no hit. After
//    re-enable, a fall gives point 15 only.

Source files
------------

// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the toggle-cover collector.
// Point ids are {bit, dir}; popcount counts newly covered points per cycle.
package toggle_cover_pkg;

  typedef enum logic {
    DIR_RISE = 1'b0,
    DIR_FALL = 1'b1
  } tc_dir_e;

  // Generous fixed widths so the helpers serve any legal WIDTH of the collector.
  localparam int ID_MAX_W = 16;
  localparam int POP_MAX  = 512;
  localparam int POP_W    = 10;

  // Cover point id: bit index in the upper bits, direction in the LSB.
  function automatic logic [ID_MAX_W-1:0] point_id(input logic [ID_MAX_W-2:0] bit_idx,
                                                   input tc_dir_e dir);
    return {bit_idx, dir};
  endfunction

  // Number of set bits in a (zero-extended) vector.
  function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] vec);
    logic [POP_W-1:0] cnt;
    cnt = {POP_W{1'b0}};
    for (int i = 0; i < POP_MAX; i++) begin
      cnt = cnt + {{(POP_W-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/toggle_cover_pick.sv
// Lowest-set-bit picker: purely combinational priority encoder.
module toggle_cover_pick
  import toggle_cover_pkg::*;
#(
  parameter int  N     = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = {IDX_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      gnt_valid = gnt_valid | req[i];
      gnt_idx   = req[i] ? i[IDX_W-1:0] : gnt_idx;
    end
  end

endmodule

// File: rtl/toggle_cover_collector.sv
// Toggle-cover collector: per-bit edge detection, toggle pulses to the reporters,
// first-hit serialisation over a valid/ready stream and a covered-point counter.
// Optional build macro TOGGLE_COVER_GATE_EN adds the cover_en detection gate.
module toggle_cover_collector
  import toggle_cover_pkg::*;
#(
  parameter int  WIDTH = 120,
  localparam int PT_W  = $clog2(2 * WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig,
  input  logic             clear_cov,
`ifdef TOGGLE_COVER_GATE_EN
  input  logic             cover_en,
`endif
  output logic [WIDTH-1:0] toggle_vld,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [PT_W-1:0]  hit_point,
  output logic [PT_W:0]    hit_count
);

  localparam int NPTS = 2 * WIDTH;

  logic [WIDTH-1:0] prev_r;
  logic             armed_r;
  logic [NPTS-1:0]  covered_r;
  logic [NPTS-1:0]  pending_r;

  logic             detect_en_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [NPTS-1:0]  new_s;
  logic [NPTS-1:0]  new_cov_s;
  logic [POP_W-1:0] new_cnt_s;
  logic             pick_en_s;
  logic             gnt_valid_s;
  logic [PT_W-1:0]  gnt_idx_s;
  logic             take_s;
  logic [NPTS-1:0]  picked_mask_s;
  logic [NPTS-1:0]  pending_next_s;
  logic [NPTS-1:0]  covered_next_s;
  logic [PT_W:0]    count_next_s;
  logic             hit_valid_next_s;
  logic [PT_W-1:0]  hit_point_next_s;

  // The first cycle after reset only loads prev, so a stale prev never looks like an edge.
`ifdef TOGGLE_COVER_GATE_EN
  assign detect_en_s = armed_r & cover_en;
`else
  assign detect_en_s = armed_r;
`endif

  // Edge detection and mapping of edges to not-yet-covered point ids.
  always_comb begin
    logic [ID_MAX_W-1:0] rid;
    logic [ID_MAX_W-1:0] fid;
    rise_s = detect_en_s ? (sig & ~prev_r) : {WIDTH{1'b0}};
    fall_s = detect_en_s ? (~sig & prev_r) : {WIDTH{1'b0}};
    new_s  = {NPTS{1'b0}};
    rid    = {ID_MAX_W{1'b0}};
    fid    = {ID_MAX_W{1'b0}};
    for (int b = 0; b < WIDTH; b++) begin
      rid = point_id(b[ID_MAX_W-2:0], DIR_RISE);
      fid = point_id(b[ID_MAX_W-2:0], DIR_FALL);
      new_s[rid[PT_W-1:0]] = rise_s[b] & ~covered_r[rid[PT_W-1:0]];
      new_s[fid[PT_W-1:0]] = fall_s[b] & ~covered_r[fid[PT_W-1:0]];
    end
  end

  // Edges seen in a clear cycle still pulse toggle_vld but never count as coverage.
  assign new_cov_s = clear_cov ? {NPTS{1'b0}} : new_s;
  assign new_cnt_s = popcount({{(POP_MAX-NPTS){1'b0}}, new_cov_s});

  toggle_cover_pick #(.N(NPTS)) u_pick (
    .req       (pending_r),
    .gnt_valid (gnt_valid_s),
    .gnt_idx   (gnt_idx_s)
  );

  // Stream control: pick only when the output slot is free or being handed over.
  always_comb begin
    pick_en_s     = ~hit_valid | hit_ready;
    take_s        = pick_en_s & gnt_valid_s & ~clear_cov;
    picked_mask_s = take_s ? ({{(NPTS-1){1'b0}}, 1'b1} << gnt_idx_s) : {NPTS{1'b0}};
    if (pick_en_s) begin
      hit_valid_next_s = take_s;
    end else begin
      hit_valid_next_s = hit_valid;
    end
    if (take_s) begin
      hit_point_next_s = gnt_idx_s;
    end else begin
      hit_point_next_s = hit_point;
    end
  end

  // Coverage bookkeeping; a clear flushes everything but the in-flight hit.
  always_comb begin
    if (clear_cov) begin
      pending_next_s = {NPTS{1'b0}};
      covered_next_s = {NPTS{1'b0}};
      count_next_s   = {(PT_W+1){1'b0}};
    end else begin
      pending_next_s = (pending_r & ~picked_mask_s) | new_cov_s;
      covered_next_s = covered_r | new_cov_s;
      count_next_s   = hit_count + new_cnt_s[PT_W:0];
    end
  end

  // State and output registers; reset takes priority over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_r     <= {WIDTH{1'b0}};
      armed_r    <= 1'b0;
      covered_r  <= {NPTS{1'b0}};
      pending_r  <= {NPTS{1'b0}};
      toggle_vld <= {WIDTH{1'b0}};
      hit_valid  <= 1'b0;
      hit_point  <= {PT_W{1'b0}};
      hit_count  <= {(PT_W+1){1'b0}};
    end else begin
      prev_r     <= sig;
      armed_r    <= 1'b1;
      covered_r  <= covered_next_s;
      pending_r  <= pending_next_s;
      toggle_vld <= rise_s | fall_s;
      hit_valid  <= hit_valid_next_s;
      hit_point  <= hit_point_next_s;
      hit_count  <= count_next_s;
    end
  end

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed self-checking bench for toggle_cover_collector (WIDTH = 120).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_toggle_cover_collector;

  localparam int W = 120;

  logic         clock;
  logic         reset;
  logic [W-1:0] sig;
  logic         clear_cov;
  logic         cover_en;
  logic [W-1:0] toggle_vld;
  logic         hit_valid;
  logic         hit_ready;
  logic [7:0]   hit_point;
  logic [8:0]   hit_count;

  int checks;
  int failures;

  toggle_cover_collector #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .sig        (sig),
    .clear_cov  (clear_cov),
`ifdef TOGGLE_COVER_GATE_EN
    .cover_en   (cover_en),
`endif
    .toggle_vld (toggle_vld),
    .hit_valid  (hit_valid),
    .hit_ready  (hit_ready),
    .hit_point  (hit_point),
    .hit_count  (hit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [W-1:0] bits(input int a, input int b);
    logic [W-1:0] v;
    v = {W{1'b0}};
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; sig = {W{1'b0}}; clear_cov = 1'b0; hit_ready = 1'b0; cover_en = 1'b1;
    step(); step();
    checks++;
    if (toggle_vld !== {W{1'b0}} || hit_valid !== 1'b0 || hit_point !== 8'd0 || hit_count !== 9'd0) begin
      failures++;
      $display("FAIL reset_state: tv=%h hv=%b hp=%0d hc=%0d, required all zero", toggle_vld, hit_valid, hit_point, hit_count);
    end
    // Release reset and toggle a bit in the arming cycle: must be ignored.
    reset = 1'b0; sig[100] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (toggle_vld !== {W{1'b0}} || hit_valid !== 1'b0 || hit_count !== 9'd0) begin
        failures++;
        $display("FAIL arm_cycle[%0d]: tv=%h hv=%b hc=%0d, required 0/0/0", i, toggle_vld, hit_valid, hit_count);
      end
    end
  endtask

  task automatic test_single_bit();
    hit_ready = 1'b1;
    sig[5] = 1'b1;
    step();
    checks++;
    if (toggle_vld !== bits(5, -1) || hit_valid !== 1'b0 || hit_count !== 9'd1) begin
      failures++;
      $display("FAIL rise5_pulse: tv=%h hv=%b hc=%0d, required bit5/0/1", toggle_vld, hit_valid, hit_count);
    end
    step();
    checks++;
    if (toggle_vld !== {W{1'b0}} || hit_valid !== 1'b1 || hit_point !== 8'd10) begin
      failures++;
      $display("FAIL rise5_hit: tv=%h hv=%b hp=%0d, required 0/1/10", toggle_vld, hit_valid, hit_point);
    end
    sig[5] = 1'b0;
    step();
    checks++;
    if (toggle_vld !== bits(5, -1) || hit_valid !== 1'b0 || hit_count !== 9'd2) begin
      failures++;
      $display("FAIL fall5_pulse: tv=%h hv=%b hc=%0d, required bit5/0/2", toggle_vld, hit_valid, hit_count);
    end
    step();
    checks++;
    if (hit_valid !== 1'b1 || hit_point !== 8'd11) begin
      failures++;
      $display("FAIL fall5_hit: hv=%b hp=%0d, required 1/11", hit_valid, hit_point);
    end
    // Repeat: pulses again, but no new hits and no count change.
    for (int r = 0; r < 2; r++) begin
      sig[5] = ~sig[5];
      step();
      checks++;
      if (toggle_vld !== bits(5, -1) || hit_valid !== 1'b0 || hit_count !== 9'd2) begin
        failures++;
        $display("FAIL repeat5_pulse[%0d]: tv=%h hv=%b hc=%0d, required bit5/0/2", r, toggle_vld, hit_valid, hit_count);
      end
      step();
      checks++;
      if (hit_valid !== 1'b0 || hit_count !== 9'd2) begin
        failures++;
        $display("FAIL repeat5_nohit[%0d]: hv=%b hc=%0d, required 0/2", r, hit_valid, hit_count);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_pt [3];
    exp_pt[0] = 8'd2; exp_pt[1] = 8'd4; exp_pt[2] = 8'd6;
    hit_ready = 1'b0;
    sig[3:0] = 4'hF;
    step();
    checks++;
    if (toggle_vld !== {{(W-4){1'b0}}, 4'hF} || hit_valid !== 1'b0 || hit_count !== 9'd6) begin
      failures++;
      $display("FAIL nibble_pulse: tv=%h hv=%b hc=%0d, required F/0/6", toggle_vld, hit_valid, hit_count);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (hit_valid !== 1'b1 || hit_point !== 8'd0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: hv=%b hp=%0d, required 1/0", i, hit_valid, hit_point);
      end
    end
    hit_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (hit_valid !== 1'b1 || hit_point !== exp_pt[i]) begin
        failures++;
        $display("FAIL drain[%0d]: hv=%b hp=%0d, required 1/%0d", i, hit_valid, hit_point, exp_pt[i]);
      end
    end
    hit_ready = 1'b0;
  endtask

  task automatic test_new_during_stall();
    sig[0] = 1'b0; sig[3] = 1'b0;
    step();
    checks++;
    if (toggle_vld !== bits(0, 3) || hit_valid !== 1'b1 || hit_point !== 8'd6 || hit_count !== 9'd8) begin
      failures++;
      $display("FAIL stall_new: tv=%h hv=%b hp=%0d hc=%0d, required bits0,3/1/6/8", toggle_vld, hit_valid, hit_point, hit_count);
    end
    step();
    checks++;
    if (hit_valid !== 1'b1 || hit_point !== 8'd6) begin
      failures++;
      $display("FAIL stall6_hold: hv=%b hp=%0d, required 1/6", hit_valid, hit_point);
    end
    hit_ready = 1'b1;
    step();
    checks++;
    if (hit_valid !== 1'b1 || hit_point !== 8'd1) begin
      failures++;
      $display("FAIL after6_low: hv=%b hp=%0d, required 1/1", hit_valid, hit_point);
    end
    step();
    checks++;
    if (hit_valid !== 1'b1 || hit_point !== 8'd7) begin
      failures++;
      $display("FAIL after1_next: hv=%b hp=%0d, required 1/7", hit_valid, hit_point);
    end
    hit_ready = 1'b0;
  endtask

  task automatic test_clear();
    sig[1] = 1'b0; sig[2] = 1'b0;
    step();
    checks++;
    if (toggle_vld !== bits(1, 2) || hit_valid !== 1'b1 || hit_point !== 8'd7 || hit_count !== 9'd10) begin
      failures++;
      $display("FAIL pre_clear: tv=%h hv=%b hp=%0d hc=%0d, required bits1,2/1/7/10", toggle_vld, hit_valid, hit_point, hit_count);
    end
    clear_cov = 1'b1; sig[6] = 1'b1;
    step();
    clear_cov = 1'b0;
    checks++;
    if (toggle_vld !== bits(6, -1) || hit_valid !== 1'b1 || hit_point !== 8'd7 || hit_count !== 9'd0) begin
      failures++;
      $display("FAIL clear_cycle: tv=%h hv=%b hp=%0d hc=%0d, required bit6/1/7/0", toggle_vld, hit_valid, hit_point, hit_count);
    end
    hit_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (hit_valid !== 1'b0 || hit_count !== 9'd0) begin
        failures++;
        $display("FAIL flushed[%0d]: hv=%b hp=%0d hc=%0d, required 0/-/0", i, hit_valid, hit_point, hit_count);
      end
    end
    sig[5] = 1'b1;
    step();
    checks++;
    if (toggle_vld !== bits(5, -1) || hit_count !== 9'd1) begin
      failures++;
      $display("FAIL rearm5_pulse: tv=%h hc=%0d, required bit5/1", toggle_vld, hit_count);
    end
    step();
    checks++;
    if (hit_valid !== 1'b1 || hit_point !== 8'd10) begin
      failures++;
      $display("FAIL rearm5_hit: hv=%b hp=%0d, required 1/10", hit_valid, hit_point);
    end
  endtask

`ifdef TOGGLE_COVER_GATE_EN
  task automatic test_gate();
    cover_en = 1'b0; sig[7] = 1'b1;
    step();
    checks++;
    if (toggle_vld !== {W{1'b0}} || hit_valid !== 1'b0 || hit_count !== 9'd1) begin
      failures++;
      $display("FAIL gated_rise: tv=%h hv=%b hc=%0d, required 0/0/1", toggle_vld, hit_valid, hit_count);
    end
    step();
    checks++;
    if (hit_valid !== 1'b0) begin
      failures++;
      $display("FAIL gated_nohit: hv=%b hp=%0d, required 0", hit_valid, hit_point);
    end
    cover_en = 1'b1; sig[7] = 1'b0;
    step();
    checks++;
    if (toggle_vld !== bits(7, -1) || hit_count !== 9'd2) begin
      failures++;
      $display("FAIL ungated_fall: tv=%h hc=%0d, required bit7/2", toggle_vld, hit_count);
    end
    step();
    checks++;
    if (hit_valid !== 1'b1 || hit_point !== 8'd15) begin
      failures++;
      $display("FAIL ungated_hit: hv=%b hp=%0d, required 1/15", hit_valid, hit_point);
    end
  endtask
`else
  task automatic test_gate();
    sig[7] = 1'b1;
    step();
    checks++;
    if (toggle_vld !== bits(7, -1) || hit_valid !== 1'b0 || hit_count !== 9'd2) begin
      failures++;
      $display("FAIL rise7_pulse: tv=%h hv=%b hc=%0d, required bit7/0/2", toggle_vld, hit_valid, hit_count);
    end
    step();
    checks++;
    if (hit_valid !== 1'b1 || hit_point !== 8'd14) begin
      failures++;
      $display("FAIL rise7_hit: hv=%b hp=%0d, required 1/14", hit_valid, hit_point);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_bit();
    test_backpressure();
    test_new_during_stall();
    test_clear();
    test_gate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
